// File: rtl/veer_types.sv
// Shared types and legal-range constants for the execution-unit multiplier.
package veer_types;

    localparam int MUL_STAGES_MIN = 3;
    localparam int MUL_STAGES_MAX = 6;

    typedef struct packed {
        logic valid;
        logic rs1_sign;
        logic rs2_sign;
        logic low;
        logic load_byp_rs1;
        logic load_byp_rs2;
    } mul_pipe_pkt_t;

endpackage

// File: rtl/exu_mul_pipe_stage.sv
// One pipeline stage: a data register plus its valid bit.
// Flush beats freeze; data loads on upstream valid (or clk_override) when not frozen.
module exu_mul_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          flush,
    input  logic          freeze,
    input  logic          clk_override,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);

    logic          vld_q, vld_d;
    logic [DW-1:0] data_q;
    logic          data_en;

    assign vld_d   = flush ? 1'b0 : (freeze ? vld_q : vld_i);
    assign data_en = (vld_i | clk_override) & ~freeze;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (data_en) data_q <= data_i;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/exu_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier: issue register, operand/bypass
// stage, then the product carried through STAGES-2 registers to the output.
module exu_mul_pipe
    import veer_types::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 clk_override,
    input  logic                 freeze,
    input  logic                 flush,
    input  mul_pipe_pkt_t        mp,
    input  logic [TAG_W-1:0]     tag_in,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     lsu_result,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [TAG_W-1:0]     tag_out
);

    if (!(WIDTH == 32 || WIDTH == 64) ||
        STAGES < MUL_STAGES_MIN || STAGES > MUL_STAGES_MAX) begin : g_bad_param
        $error("exu_mul_pipe: illegal WIDTH=%0d or STAGES=%0d", WIDTH, STAGES);
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             s1;
        logic             s2;
        logic             low;
        logic             byp1;
        logic             byp2;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } iss_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             low;
        logic             neg_a;
        logic [WIDTH-1:0] opa;
        logic             neg_b;
        logic [WIDTH-1:0] opb;
    } opr_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic               low;
        logic [2*WIDTH-1:0] prod;
    } prd_t;

    logic [STAGES:0] vld_pipe;
    iss_t            iss_d, iss_q;
    opr_t            opr_d, opr_q;
    prd_t            prd_in;
    prd_t            prd_pipe [0:STAGES-2];

    logic signed [2*WIDTH-1:0] xa, xb;

    assign vld_pipe[0] = mp.valid;

    always_comb begin
        iss_d      = '0;
        iss_d.tag  = tag_in;
        iss_d.s1   = mp.rs1_sign;
        iss_d.s2   = mp.rs2_sign;
        iss_d.low  = mp.low;
        iss_d.byp1 = mp.load_byp_rs1;
        iss_d.byp2 = mp.load_byp_rs2;
        iss_d.a    = a;
        iss_d.b    = b;
    end

    exu_mul_pipe_stage #(.DW($bits(iss_t))) u_iss (
        .clk(clk), .rst_l(rst_l), .flush(flush), .freeze(freeze),
        .clk_override(clk_override),
        .vld_i(vld_pipe[0]), .data_i(iss_d),
        .vld_o(vld_pipe[1]), .data_o(iss_q)
    );

    // Load data replaces the operand here so a late-arriving load can feed the multiply.
    always_comb begin
        opr_d       = '0;
        opr_d.tag   = iss_q.tag;
        opr_d.low   = iss_q.low;
        opr_d.opa   = iss_q.byp1 ? lsu_result : iss_q.a;
        opr_d.opb   = iss_q.byp2 ? lsu_result : iss_q.b;
        opr_d.neg_a = iss_q.s1 & opr_d.opa[WIDTH-1];
        opr_d.neg_b = iss_q.s2 & opr_d.opb[WIDTH-1];
    end

    exu_mul_pipe_stage #(.DW($bits(opr_t))) u_opr (
        .clk(clk), .rst_l(rst_l), .flush(flush), .freeze(freeze),
        .clk_override(clk_override),
        .vld_i(vld_pipe[1]), .data_i(opr_d),
        .vld_o(vld_pipe[2]), .data_o(opr_q)
    );

    // Sign-extending the (WIDTH+1)-bit operands to 2*WIDTH gives the exact low 2*WIDTH product bits.
    assign xa = {{(WIDTH-1){opr_q.neg_a}}, opr_q.neg_a, opr_q.opa};
    assign xb = {{(WIDTH-1){opr_q.neg_b}}, opr_q.neg_b, opr_q.opb};

    always_comb begin
        prd_in      = '0;
        prd_in.tag  = opr_q.tag;
        prd_in.low  = opr_q.low;
        prd_in.prod = xa * xb;
    end

    assign prd_pipe[0] = prd_in;

    for (genvar i = 0; i < STAGES - 2; i++) begin : g_prd
        exu_mul_pipe_stage #(.DW($bits(prd_t))) u_prd (
            .clk(clk), .rst_l(rst_l), .flush(flush), .freeze(freeze),
            .clk_override(clk_override),
            .vld_i(vld_pipe[2+i]), .data_i(prd_pipe[i]),
            .vld_o(vld_pipe[3+i]), .data_o(prd_pipe[i+1])
        );
    end

    always_comb begin
        out_valid = vld_pipe[STAGES];
        out       = '0;
        tag_out   = '0;
        if (out_valid) begin
            out     = prd_pipe[STAGES-2].low ? prd_pipe[STAGES-2].prod[WIDTH-1:0]
                                             : prd_pipe[STAGES-2].prod[2*WIDTH-1:WIDTH];
            tag_out = prd_pipe[STAGES-2].tag;
        end
    end

endmodule

// File: tb/tb_exu_mul_pipe.sv
// Bench for exu_mul_pipe: 32-bit/3-stage instance against an occupancy model,
// plus a 64-bit/6-stage instance for the wide-operand and deep-pipe cases.
module tb_exu_mul_pipe;
    import veer_types::*;

    localparam int S  = 3;
    localparam int TW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_l, clk_override, freeze, flush;
    mul_pipe_pkt_t mp;
    logic [TW-1:0] tag_in;
    logic [31:0] a, b, lsu, out;
    logic out_valid;
    logic [TW-1:0] tag_out;
    logic [63:0] a64, b64, lsu64, out64;
    logic ov64;
    logic [TW-1:0] tag64;

    int checks = 0;
    int errors = 0;

    exu_mul_pipe #(.WIDTH(32), .STAGES(S), .TAG_W(TW)) dut (
        .clk(clk), .rst_l(rst_l), .clk_override(clk_override), .freeze(freeze),
        .flush(flush), .mp(mp), .tag_in(tag_in), .a(a), .b(b), .lsu_result(lsu),
        .out(out), .out_valid(out_valid), .tag_out(tag_out)
    );

    exu_mul_pipe #(.WIDTH(64), .STAGES(6), .TAG_W(TW)) dut64 (
        .clk(clk), .rst_l(rst_l), .clk_override(clk_override), .freeze(freeze),
        .flush(flush), .mp(mp), .tag_in(tag_in), .a(a64), .b(b64), .lsu_result(lsu64),
        .out(out64), .out_valid(ov64), .tag_out(tag64)
    );

    // Exact product from the arithmetic definition, then high/low half select.
    function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y,
                                            input bit s1, input bit s2, input bit lo);
        logic signed [131:0] sx, sy, p;
        logic [131:0] r;
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sx = '0; sx[63:0] = x & m;
        sy = '0; sy[63:0] = y & m;
        if (s1 && x[w-1]) sx = sx - (132'sd1 <<< w);
        if (s2 && y[w-1]) sy = sy - (132'sd1 <<< w);
        p = sx * sy;
        r = lo ? p : (p >>> w);
        return r[63:0] & m;
    endfunction

    typedef struct {
        bit v;
        logic [63:0] a, b;
        bit s1, s2, low, by1, by2;
        logic [TW-1:0] tag;
        logic [63:0] res;
    } op_t;

    op_t pipe [S];

    // Occupancy model: an op moves one slot per unfrozen cycle, operands resolve on entry to slot 1.
    task automatic tick();
        logic [63:0] oa, ob;
        if (flush) begin
            for (int i = 0; i < S; i++) pipe[i].v = 1'b0;
        end else if (!freeze) begin
            for (int i = S - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (pipe[1].v) begin
                oa = pipe[1].by1 ? {32'd0, lsu} : pipe[1].a;
                ob = pipe[1].by2 ? {32'd0, lsu} : pipe[1].b;
                pipe[1].res = ref_mul(32, oa, ob, pipe[1].s1, pipe[1].s2, pipe[1].low);
            end
            pipe[0].v = mp.valid; pipe[0].a = {32'd0, a}; pipe[0].b = {32'd0, b};
            pipe[0].s1 = mp.rs1_sign; pipe[0].s2 = mp.rs2_sign; pipe[0].low = mp.low;
            pipe[0].by1 = mp.load_byp_rs1; pipe[0].by2 = mp.load_byp_rs2;
            pipe[0].tag = tag_in;
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input bit s1, input bit s2,
                         input bit lo, input bit b1, input bit b2, input logic [TW-1:0] t);
        a = xa; b = xb; tag_in = t;
        mp.valid = 1'b1; mp.rs1_sign = s1; mp.rs2_sign = s2; mp.low = lo;
        mp.load_byp_rs1 = b1; mp.load_byp_rs2 = b2;
        tick();
        mp.valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_l = 1'b0; mp = '0; freeze = 0; flush = 0; clk_override = 0;
        for (int i = 0; i < S; i++) pipe[i].v = 1'b0;
        @(posedge clk); #1;
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        int seen;
        rst_l = 1'b0; mp = '0; freeze = 0; flush = 0; clk_override = 0; tag_in = '0;
        a = '0; b = '0; lsu = '0; a64 = '0; b64 = '0; lsu64 = '0;
        for (int i = 0; i < S; i++) pipe[i].v = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'd0 || tag_out !== '0 || ov64 !== 1'b0 || out64 !== 64'd0) begin
            errors++; $display("FAIL reset_init v=%b out=%h tag=%h v64=%b out64=%h required all zero",
                               out_valid, out, tag_out, ov64, out64);
        end
        @(posedge clk); #1; rst_l = 1'b1;
        issue(32'd3, 32'd4, 0, 0, 1, 0, 0, 5'd1);
        issue(32'd5, 32'd6, 0, 0, 1, 0, 0, 5'd2);
        #2 rst_l = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out !== 32'd0 || tag_out !== '0) begin
            errors++; $display("FAIL reset_async v=%b out=%h tag=%h required zero", out_valid, out, tag_out);
        end
        for (int i = 0; i < S; i++) pipe[i].v = 1'b0;
        @(posedge clk); #1; rst_l = 1'b1;
        // first edge after release must accept an issue
        issue(32'd9, 32'd9, 0, 0, 1, 0, 0, 5'd9);
        seen = 0;
        for (int e = 2; e <= S + 3; e++) begin
            tick();
            if (out_valid === 1'b1) seen++;
            checks++;
            if (out_valid !== (e == S) || (e == S && (out !== 32'd81 || tag_out !== 5'd9))) begin
                errors++; $display("FAIL reset_reissue edge%0d v=%b out=%0d tag=%0d required v=%b out=81 tag=9",
                                   e, out_valid, out, tag_out, (e == S));
            end
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("FAIL reset_discard results=%0d required 1", seen);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h99};
        logic [31:0] vb [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd6};
        bit vs1 [4] = '{1, 0, 1, 0};
        bit vs2 [4] = '{1, 0, 0, 0};
        bit vlo [4] = '{1, 0, 0, 1};
        bit vby [4] = '{0, 0, 0, 1};
        logic [31:0] vex [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd30};
        for (int v = 0; v < 4; v++) begin
            lsu = 32'hDEAD_0000;
            issue(va[v], vb[v], vs1[v], vs2[v], vlo[v], vby[v], 0, TW'(v + 10));
            for (int e = 1; e <= S + 1; e++) begin
                if (e > 1) tick();
                checks++;
                if (e == S) begin
                    if (out_valid !== 1'b1 || out !== vex[v] || tag_out !== TW'(v + 10)) begin
                        errors++; $display("FAIL dir%0d edge%0d v=%b out=%h tag=%0d required v=1 out=%h tag=%0d",
                                           v, e, out_valid, out, tag_out, vex[v], v + 10);
                    end
                end else if (out_valid !== 1'b0 || out !== 32'd0 || tag_out !== '0) begin
                    errors++; $display("FAIL dir%0d edge%0d v=%b out=%h tag=%0d required idle zeros",
                                       v, e, out_valid, out, tag_out);
                end
                lsu = (e == 1) ? 32'd5 : 32'hDEAD_0000;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa [4], xb [4];
        int iss_e [4] = '{1, 2, 5, 6};
        int k;
        int rt [$], re [$];
        logic [31:0] rv [$];
        logic [31:0] exp_o;
        k = 0;
        for (int i = 0; i < 4; i++) begin xa[i] = $urandom; xb[i] = $urandom; end
        for (int e = 1; e <= 12; e++) begin
            freeze = (e == 3 || e == 4);
            if (k < 4 && e == iss_e[k]) begin
                issue(xa[k], xb[k], 1, 0, 0, 0, 0, TW'(k + 1));
                k++;
            end else tick();
            freeze = 1'b0;
            exp_o = pipe[S-1].v ? pipe[S-1].res[31:0] : 32'd0;
            checks++;
            if (out_valid !== pipe[S-1].v || out !== exp_o) begin
                errors++; $display("FAIL b2b edge%0d v=%b out=%h required v=%b out=%h",
                                   e, out_valid, out, pipe[S-1].v, exp_o);
            end
            if (out_valid === 1'b1) begin rt.push_back(int'(tag_out)); re.push_back(e); rv.push_back(out); end
        end
        checks++;
        if (rt.size() != 4) begin
            errors++; $display("FAIL b2b_count results=%0d required 4", rt.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_o = ref_mul(32, {32'd0, xa[i]}, {32'd0, xb[i]}, 1, 0, 0);
                checks++;
                if (rt[i] != i + 1 || re[i] != 5 + i || rv[i] !== exp_o) begin
                    errors++; $display("FAIL b2b_res%0d tag=%0d edge=%0d out=%h required tag=%0d edge=%0d out=%h",
                                       i, rt[i], re[i], rv[i], i + 1, 5 + i, exp_o);
                end
            end
        end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        issue(32'd11, 32'd12, 0, 0, 1, 0, 0, 5'd1);
        issue(32'd13, 32'd14, 0, 0, 1, 0, 0, 5'd2);
        flush = 1'b1;
        issue(32'd15, 32'd16, 0, 0, 1, 0, 0, 5'd3);
        flush = 1'b0;
        issue(32'd17, 32'd18, 0, 0, 1, 0, 0, 5'd4);
        freeze = 1'b1; flush = 1'b1;
        tick();
        freeze = 1'b0; flush = 1'b0;
        for (int e = 0; e < 6; e++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_kill results=%0d required 0", seen);
        end
        issue(32'd20, 32'd21, 0, 0, 1, 0, 0, 5'd7);
        for (int e = 2; e <= S + 1; e++) begin
            tick();
            checks++;
            if (out_valid !== (e == S) || (e == S && (out !== 32'd420 || tag_out !== 5'd7))) begin
                errors++; $display("FAIL flush_next edge%0d v=%b out=%0d tag=%0d required v=%b out=420 tag=7",
                                   e, out_valid, out, tag_out, (e == S));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF};
        logic [31:0] exp_o;
        logic [TW-1:0] exp_t;
        for (int c = 0; c < 400; c++) begin
            a = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            b = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            lsu = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            tag_in = TW'($urandom);
            mp = mul_pipe_pkt_t'($urandom);
            freeze = ($urandom_range(4) == 0);
            flush = ($urandom_range(19) == 0);
            clk_override = $urandom_range(1);
            tick();
            exp_o = pipe[S-1].v ? pipe[S-1].res[31:0] : 32'd0;
            exp_t = pipe[S-1].v ? pipe[S-1].tag : '0;
            checks++;
            if (out_valid !== pipe[S-1].v || out !== exp_o || tag_out !== exp_t) begin
                errors++; $display("FAIL rand cyc%0d v=%b out=%h tag=%h required v=%b out=%h tag=%h",
                                   c, out_valid, out, tag_out, pipe[S-1].v, exp_o, exp_t);
            end
        end
        mp = '0; freeze = 0; flush = 0; clk_override = 0;
    endtask

    task automatic test_w64();
        logic [63:0] xa [4], xb [4], ex;
        bit s1 [4], s2 [4], lo [4];
        int seen;
        do_reset();
        xa[0] = 64'h8000_0000_0000_0000; xb[0] = 64'd2; s1[0] = 1; s2[0] = 0; lo[0] = 0;
        for (int i = 1; i < 4; i++) begin
            xa[i] = {$urandom, $urandom}; xb[i] = {$urandom, $urandom};
            s1[i] = $urandom_range(1); s2[i] = $urandom_range(1); lo[i] = $urandom_range(1);
        end
        for (int v = 0; v < 4; v++) begin
            ex = ref_mul(64, xa[v], xb[v], s1[v], s2[v], lo[v]);
            if (v == 0) ex = 64'hFFFF_FFFF_FFFF_FFFF;
            a64 = xa[v]; b64 = xb[v]; tag_in = TW'(v + 20);
            mp = '0; mp.valid = 1; mp.rs1_sign = s1[v]; mp.rs2_sign = s2[v]; mp.low = lo[v];
            @(posedge clk); #1; mp.valid = 1'b0;
            for (int e = 1; e <= 7; e++) begin
                if (e > 1) begin @(posedge clk); #1; end
                checks++;
                if (ov64 !== (e == 6) || (e == 6 && (out64 !== ex || tag64 !== TW'(v + 20)))) begin
                    errors++; $display("FAIL w64_%0d edge%0d v=%b out=%h tag=%0d required v=%b out=%h tag=%0d",
                                       v, e, ov64, out64, tag64, (e == 6), ex, v + 20);
                end
            end
        end
        mp.valid = 1'b1;
        @(posedge clk); #1; mp.valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_l = 1'b0;
        @(posedge clk); #1; rst_l = 1'b1;
        seen = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (ov64 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL w64_reset results=%0d required 0", seen);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_w64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_mul_pipe.md
EXU_MUL_PIPE -- requirements
Module: exu_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; legal values 32 and 64.
REQ-002 Parameter STAGES, default 3, issue-to-result latency in cycles; legal range 3..6.
REQ-003 Parameter TAG_W, default 5, width of the sideband tag carried with each operation.
REQ-004 clk  in  1  single clock for all state.
REQ-005 rst_l  in  1  reset, asynchronous, active-low.
REQ-006 clk_override  in  1  forces every data-register enable true, except while frozen.
REQ-007 freeze  in  1  pipeline hold; no stage advances.
REQ-008 flush  in  1  kills every in-flight operation.
REQ-009 mp  in  mul_pipe_pkt_t  valid, rs1_sign, rs2_sign, low, load_byp_rs1, load_byp_rs2.
REQ-010 tag_in  in  TAG_W  sideband tag, captured with mp.valid.
REQ-011 a, b  in  WIDTH each  operands, sampled at the issue edge.
REQ-012 lsu_result  in  WIDTH  load data, muxed in at stage 1.
REQ-013 out  out  WIDTH  result.
REQ-014 out_valid  out  1  out and tag_out are valid.
REQ-015 tag_out  out  TAG_W  tag of the operation presented on out.

Function
REQ-016 Issue: when mp.valid=1 and freeze=0 and flush=0, the block SHALL capture a, b, tag_in and all mp fields at the rising edge.
REQ-017 Stage 1: the block SHALL substitute lsu_result for each captured operand whose load_byp bit is set, then form neg = sign & operand[WIDTH-1].
REQ-018 Stage 2: the block SHALL register the {neg, operand} pairs and compute the signed (WIDTH+1)x(WIDTH+1) product.
REQ-019 Product path: the block SHALL carry product[2*WIDTH-1:0] through STAGES-2 registers, giving a latency of exactly STAGES edges from issue to out_valid.
REQ-020 Result select: out SHALL equal product[WIDTH-1:0] when low=1, and product[2*WIDTH-1:WIDTH] otherwise.
REQ-021 out and tag_out SHALL be 0 whenever out_valid=0.
REQ-022 Each stage SHALL hold a valid bit; data registers SHALL load only when the upstream valid bit (or clk_override) is 1 and freeze=0.
REQ-023 Throughput: the block SHALL accept one operation per cycle, with no bubbles between back-to-back issues.
REQ-024 Freeze: with freeze=1, all valid and data registers SHALL hold their values, out_valid SHALL remain asserted if already asserted, and mp.valid SHALL be ignored.
REQ-025 Flush: at the edge where flush=1, all valid bits SHALL clear, and a same-cycle mp.valid SHALL be dropped.
REQ-026 Flush SHALL take priority over freeze.
REQ-027 The load-bypass select bits SHALL affect stage 1 only; lsu_result is sampled in the cycle the operation occupies stage 1 and freeze=0.
REQ-028 Arithmetic SHALL be exact two's-complement for all four sign combinations, with no overflow or saturation.

Reset
REQ-029 While rst_l=0, all valid bits and all data and tag registers SHALL clear asynchronously; out=0, out_valid=0, tag_out=0.
REQ-030 A reset asserted while operations are in flight SHALL discard them; no out_valid SHALL follow its deassertion until a new operation is issued.
REQ-031 Reset release SHALL be synchronised outside this block; the block SHALL accept an issue on the first edge after release.

Structure
REQ-032 mul_pipe_pkt_t SHALL be defined in veer_types.
REQ-033 The legal-range constants MUL_STAGES_MIN=3 and MUL_STAGES_MAX=6 SHALL be defined in veer_types.
REQ-034 Illegal WIDTH or STAGES SHALL trigger an elaboration-time assertion.
REQ-035 One sub-module, exu_mul_pipe_stage, SHALL implement the parametrised data register plus its valid bit and enable/flush logic.
REQ-036 The product registers SHALL be built by instantiating exu_mul_pipe_stage in a generate loop.

Verification
REQ-037 MUL signed-low, WIDTH=32/STAGES=3: a=7, b=0xFFFFFFFD, both signs set, low=1 -> out=0xFFFFFFEB, out_valid high for 1 cycle, exactly 3 edges after issue.
REQ-038 MULHU: a=b=0xFFFFFFFF, signs clear, low=0 -> out=0xFFFFFFFE. MULHSU: a=0xFFFFFFFF with rs1_sign=1, b=2, low=0 -> out=0xFFFFFFFF.
REQ-039 Load bypass: load_byp_rs1=1, a=0x99, lsu_result=5 in stage-1 cycle, b=6, low=1 -> out=30.
REQ-040 Back-to-back: 4 consecutive issues with tags 1..4 and a 2-cycle freeze mid-flight -> results in order, tags 1..4, each out_valid delayed by exactly 2 cycles, values intact.
REQ-041 Flush with 3 in flight plus a same-cycle issue -> no out_valid for any of them; the next issue completes normally after STAGES edges.
REQ-042 WIDTH=64/STAGES=6: a=0x8000000000000000 signed, b=2 unsigned, low=0 -> out=0xFFFFFFFFFFFFFFFF, latency 6; reset mid-flight -> no out_valid.
